// File: rtl/pigro_pkg.sv
// Shared PIGRO pipeline definitions: controller states, datapath widths and the
// opcode encodings that upstream decode turns into ld_ex / halt_wb.
package pigro_pkg;

  localparam int PIGRO_AW  = 4;
  localparam int PIGRO_PCW = 5;
  localparam int PIGRO_OPW = 4;

  localparam logic [PIGRO_OPW-1:0] OP_LOAD = 4'h8;
  localparam logic [PIGRO_OPW-1:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDSTALL = 2'd1,
    FLUSH   = 2'd2,
    HALT    = 2'd3
  } pc_state_e;

  function automatic logic is_load(input logic [PIGRO_OPW-1:0] op);
    return op == OP_LOAD;
  endfunction

  function automatic logic is_halt(input logic [PIGRO_OPW-1:0] op);
    return op == OP_HALT;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard/sequencing bundle between the pipeline datapath (master) and pipe_ctrl (slave).
// Stage tags: _re = read stage, _ex = execute, _wb = writeback.
interface pipe_ctrl_if #(
  parameter int AW   = pigro_pkg::PIGRO_AW,
  parameter int PCW  = pigro_pkg::PIGRO_PCW,
  parameter int CNTW = 16
);
  logic            ld_ex;
  logic [AW-1:0]   dadd_ex;
  logic [AW-1:0]   add_a_re;
  logic [AW-1:0]   add_b_re;
  logic            use_a_re;
  logic            use_b_re;
  logic            br_taken_ex;
  logic [PCW-1:0]  bta_ex;
  logic            halt_wb;

  logic            stall_fe;
  logic            stall_re;
  logic            bubble_ex;
  logic            flush_fe;
  logic            flush_re;
  logic            pc_load;
  logic [PCW-1:0]  pc_target;
  logic            halted;
  logic [CNTW-1:0] stall_cnt;
  logic [CNTW-1:0] flush_cnt;

  modport master (
    output ld_ex, dadd_ex, add_a_re, add_b_re, use_a_re, use_b_re,
           br_taken_ex, bta_ex, halt_wb,
    input  stall_fe, stall_re, bubble_ex, flush_fe, flush_re,
           pc_load, pc_target, halted, stall_cnt, flush_cnt
  );

  modport slave (
    input  ld_ex, dadd_ex, add_a_re, add_b_re, use_a_re, use_b_re,
           br_taken_ex, bta_ex, halt_wb,
    output stall_fe, stall_re, bubble_ex, flush_fe, flush_re,
           pc_load, pc_target, halted, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating event counter: +1 per cycle with en high, sticks at all-ones.
// Synchronous clear has priority; the value is visible the cycle after the event.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         en,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (clear) begin
      cnt <= '0;
    end else if (en && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// PIGRO hazard/sequencing controller: load-use stalls, taken-branch redirect, HALT freeze.
// Controls are Mealy (same-cycle); state and event counters update on the clock edge.
module pipe_ctrl
  import pigro_pkg::*;
#(
  parameter int AW        = PIGRO_AW,
  parameter int PCW       = PIGRO_PCW,
  parameter int CNTW      = 16,
  parameter int LD_STALL  = 1,
  parameter int FLUSH_CYC = 1
) (
  input logic       clk,
  input logic       rst,
  pipe_ctrl_if.slave pif
);

  localparam int MAXC = (LD_STALL > FLUSH_CYC) ? LD_STALL : FLUSH_CYC;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  pc_state_e state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  logic [AW-1:0]  dadd, add_a, add_b;
  logic [PCW-1:0] bta;
  logic           hz;
  logic           stall, bubble, flush, pc_load, halted;
  logic           stall_inc;
  logic [CNTW-1:0] stall_cnt, flush_cnt;

  assign dadd  = pif.dadd_ex;
  assign add_a = pif.add_a_re;
  assign add_b = pif.add_b_re;
  assign bta   = pif.bta_ex;

  // Every register address is a real register, so r0 matches like any other.
  assign hz = pif.ld_ex & ((pif.use_a_re & (add_a == dadd)) |
                           (pif.use_b_re & (add_b == dadd)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    stall     = 1'b0;
    bubble    = 1'b0;
    flush     = 1'b0;
    pc_load   = 1'b0;
    halted    = 1'b0;
    unique case (state)
      RUN: begin
        if (pif.halt_wb) begin
          stall     = 1'b1;
          bubble    = 1'b1;
          state_nxt = HALT;
        end else if (pif.br_taken_ex) begin
          pc_load   = 1'b1;
          flush     = 1'b1;
          state_nxt = FLUSH;
          cnt_nxt   = CW'(FLUSH_CYC - 1);
        end else if (hz) begin
          stall  = 1'b1;
          bubble = 1'b1;
          // The RUN cycle is the first stall cycle, so LDSTALL covers the remainder.
          if (LD_STALL > 1) begin
            state_nxt = LDSTALL;
            cnt_nxt   = CW'(LD_STALL - 2);
          end
        end
      end
      LDSTALL: begin
        stall  = 1'b1;
        bubble = 1'b1;
        if (pif.halt_wb) begin
          state_nxt = HALT;
        end else if (cnt == '0) begin
          state_nxt = RUN;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      FLUSH: begin
        bubble = 1'b1;
        if (pif.halt_wb) begin
          state_nxt = HALT;
        end else if (cnt == '0) begin
          state_nxt = RUN;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      HALT: begin
        stall  = 1'b1;
        bubble = 1'b1;
        halted = 1'b1;
      end
      default: state_nxt = RUN;
    endcase
    if (rst) begin
      stall   = 1'b0;
      bubble  = 1'b0;
      flush   = 1'b0;
      pc_load = 1'b0;
      halted  = 1'b0;
    end
  end

  assign stall_inc = stall & (state != HALT);

  sat_counter #(.W(CNTW)) u_stall_cnt (
    .clk   (clk),
    .clear (rst),
    .en    (stall_inc),
    .cnt   (stall_cnt)
  );

  sat_counter #(.W(CNTW)) u_flush_cnt (
    .clk   (clk),
    .clear (rst),
    .en    (pc_load),
    .cnt   (flush_cnt)
  );

  assign pif.stall_fe  = stall;
  assign pif.stall_re  = stall;
  assign pif.bubble_ex = bubble;
  assign pif.flush_fe  = flush;
  assign pif.flush_re  = flush;
  assign pif.pc_load   = pc_load;
  assign pif.pc_target = pc_load ? bta : '0;
  assign pif.halted    = halted;
  assign pif.stall_cnt = stall_cnt;
  assign pif.flush_cnt = flush_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: default build, LD_STALL=3 build and CNTW=4 build share stimulus.
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       ld_ex, use_a_re, use_b_re, br_taken_ex, halt_wb;
  logic [3:0] dadd_ex, add_a_re, add_b_re;
  logic [4:0] bta_ex;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_ctrl_if #(.AW(4), .PCW(5), .CNTW(16)) if0 ();
  pipe_ctrl_if #(.AW(4), .PCW(5), .CNTW(16)) if3 ();
  pipe_ctrl_if #(.AW(4), .PCW(5), .CNTW(4))  if4 ();

  pipe_ctrl #(.AW(4), .PCW(5), .CNTW(16), .LD_STALL(1), .FLUSH_CYC(1))
    u0 (.clk(clk), .rst(rst), .pif(if0));
  pipe_ctrl #(.AW(4), .PCW(5), .CNTW(16), .LD_STALL(3), .FLUSH_CYC(1))
    u3 (.clk(clk), .rst(rst), .pif(if3));
  pipe_ctrl #(.AW(4), .PCW(5), .CNTW(4), .LD_STALL(1), .FLUSH_CYC(1))
    u4 (.clk(clk), .rst(rst), .pif(if4));

  assign if0.ld_ex = ld_ex;       assign if3.ld_ex = ld_ex;       assign if4.ld_ex = ld_ex;
  assign if0.dadd_ex = dadd_ex;   assign if3.dadd_ex = dadd_ex;   assign if4.dadd_ex = dadd_ex;
  assign if0.add_a_re = add_a_re; assign if3.add_a_re = add_a_re; assign if4.add_a_re = add_a_re;
  assign if0.add_b_re = add_b_re; assign if3.add_b_re = add_b_re; assign if4.add_b_re = add_b_re;
  assign if0.use_a_re = use_a_re; assign if3.use_a_re = use_a_re; assign if4.use_a_re = use_a_re;
  assign if0.use_b_re = use_b_re; assign if3.use_b_re = use_b_re; assign if4.use_b_re = use_b_re;
  assign if0.br_taken_ex = br_taken_ex;
  assign if3.br_taken_ex = br_taken_ex;
  assign if4.br_taken_ex = br_taken_ex;
  assign if0.bta_ex = bta_ex;     assign if3.bta_ex = bta_ex;     assign if4.bta_ex = bta_ex;
  assign if0.halt_wb = halt_wb;   assign if3.halt_wb = halt_wb;   assign if4.halt_wb = halt_wb;

  // {stall_fe, stall_re, bubble_ex, flush_fe, flush_re, pc_load, halted}
  wire [6:0] ctl0 = {if0.stall_fe, if0.stall_re, if0.bubble_ex, if0.flush_fe,
                     if0.flush_re, if0.pc_load, if0.halted};

  task automatic idle();
    ld_ex = 0; use_a_re = 0; use_b_re = 0; br_taken_ex = 0; halt_wb = 0;
    dadd_ex = 0; add_a_re = 0; add_b_re = 0; bta_ex = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hazard();
    ld_ex = 1; dadd_ex = 4'd3; add_a_re = 4'd3; use_a_re = 1;
  endtask

  task automatic do_reset();
    rst = 1;
    idle();
    tick();
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    hazard(); br_taken_ex = 1; bta_ex = 5'h07; halt_wb = 1;
    @(negedge clk);
    checks++; if (ctl0 !== 7'h00) begin errors++; $display("FAIL reset_ctl: got %b expected %b", ctl0, 7'h00); end
    checks++; if (if0.pc_target !== 5'h00) begin errors++; $display("FAIL reset_target: got %h expected 00", if0.pc_target); end
    tick();
    checks++; if (if0.stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall_cnt: got %0d expected 0", if0.stall_cnt); end
    checks++; if (if0.flush_cnt !== 16'd0) begin errors++; $display("FAIL reset_flush_cnt: got %0d expected 0", if0.flush_cnt); end
    rst = 0;
    idle();
    @(negedge clk);
    checks++; if (ctl0 !== 7'h00) begin errors++; $display("FAIL reset_exit_run: got %b expected %b", ctl0, 7'h00); end
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    hazard();
    @(negedge clk);
    checks++; if (ctl0 !== 7'h70) begin errors++; $display("FAIL lu_stall: got %b expected %b", ctl0, 7'h70); end
    tick();
    idle();
    @(negedge clk);
    checks++; if (ctl0 !== 7'h00) begin errors++; $display("FAIL lu_one_cycle: got %b expected %b", ctl0, 7'h00); end
    checks++; if (if0.stall_cnt !== 16'd1) begin errors++; $display("FAIL lu_stall_cnt: got %0d expected 1", if0.stall_cnt); end
    tick();
  endtask

  task automatic test_no_false_hazard();
    do_reset();
    hazard(); use_a_re = 0;
    @(negedge clk);
    checks++; if (ctl0 !== 7'h00) begin errors++; $display("FAIL nf_use_a_off: got %b expected %b", ctl0, 7'h00); end
    tick();
    idle(); ld_ex = 1; dadd_ex = 4'd3; add_a_re = 4'd5; use_a_re = 1; add_b_re = 4'd3; use_b_re = 0;
    @(negedge clk);
    checks++; if (ctl0 !== 7'h00) begin errors++; $display("FAIL nf_use_b_off: got %b expected %b", ctl0, 7'h00); end
    tick();
    idle(); dadd_ex = 4'd3; add_a_re = 4'd3; use_a_re = 1;
    @(negedge clk);
    checks++; if (ctl0 !== 7'h00) begin errors++; $display("FAIL nf_not_load: got %b expected %b", ctl0, 7'h00); end
    tick();
    checks++; if (if0.stall_cnt !== 16'd0) begin errors++; $display("FAIL nf_stall_cnt: got %0d expected 0", if0.stall_cnt); end
    idle(); ld_ex = 1; dadd_ex = 4'd3; add_b_re = 4'd3; use_b_re = 1;
    @(negedge clk);
    checks++; if (ctl0 !== 7'h70) begin errors++; $display("FAIL hz_src_b: got %b expected %b", ctl0, 7'h70); end
    tick();
    idle(); ld_ex = 1; dadd_ex = 4'd0; add_a_re = 4'd0; use_a_re = 1;
    @(negedge clk);
    checks++; if (ctl0 !== 7'h70) begin errors++; $display("FAIL hz_reg0: got %b expected %b", ctl0, 7'h70); end
    tick();
    idle();
    checks++; if (if0.stall_cnt !== 16'd2) begin errors++; $display("FAIL hz_stall_cnt: got %0d expected 2", if0.stall_cnt); end
  endtask

  task automatic test_branch();
    do_reset();
    br_taken_ex = 1; bta_ex = 5'h12;
    @(negedge clk);
    checks++; if (ctl0 !== 7'h0E) begin errors++; $display("FAIL br_ctl: got %b expected %b", ctl0, 7'h0E); end
    checks++; if (if0.pc_target !== 5'h12) begin errors++; $display("FAIL br_target: got %h expected 12", if0.pc_target); end
    tick();
    idle(); hazard(); br_taken_ex = 1; bta_ex = 5'h03;
    @(negedge clk);
    checks++; if (ctl0 !== 7'h10) begin errors++; $display("FAIL br_bubble: got %b expected %b", ctl0, 7'h10); end
    checks++; if (if0.pc_target !== 5'h00) begin errors++; $display("FAIL br_flush_target: got %h expected 00", if0.pc_target); end
    checks++; if (if0.flush_cnt !== 16'd1) begin errors++; $display("FAIL br_flush_cnt: got %0d expected 1", if0.flush_cnt); end
    tick();
    idle();
    @(negedge clk);
    checks++; if (ctl0 !== 7'h00) begin errors++; $display("FAIL br_back_run: got %b expected %b", ctl0, 7'h00); end
    checks++; if (if0.flush_cnt !== 16'd1) begin errors++; $display("FAIL br_flush_cnt_hold: got %0d expected 1", if0.flush_cnt); end
    checks++; if (if0.stall_cnt !== 16'd0) begin errors++; $display("FAIL br_stall_cnt: got %0d expected 0", if0.stall_cnt); end
    tick();
  endtask

  task automatic test_priority();
    do_reset();
    hazard(); br_taken_ex = 1; bta_ex = 5'h0A;
    @(negedge clk);
    checks++; if (ctl0 !== 7'h0E) begin errors++; $display("FAIL pri_br_over_hz: got %b expected %b", ctl0, 7'h0E); end
    tick();
    idle();
    @(negedge clk);
    checks++; if (ctl0 !== 7'h10) begin errors++; $display("FAIL pri_flush_bubble: got %b expected %b", ctl0, 7'h10); end
    tick();
    checks++; if (if0.stall_cnt !== 16'd0) begin errors++; $display("FAIL pri_stall_cnt: got %0d expected 0", if0.stall_cnt); end
    checks++; if (if0.flush_cnt !== 16'd1) begin errors++; $display("FAIL pri_flush_cnt: got %0d expected 1", if0.flush_cnt); end
    do_reset();
    halt_wb = 1; br_taken_ex = 1; bta_ex = 5'h1F;
    @(negedge clk);
    checks++; if (ctl0 !== 7'h70) begin errors++; $display("FAIL pri_halt_over_br: got %b expected %b", ctl0, 7'h70); end
    checks++; if (if0.pc_target !== 5'h00) begin errors++; $display("FAIL pri_halt_target: got %h expected 00", if0.pc_target); end
    tick();
    idle();
    @(negedge clk);
    checks++; if (ctl0 !== 7'h71) begin errors++; $display("FAIL pri_halted: got %b expected %b", ctl0, 7'h71); end
    checks++; if (if0.flush_cnt !== 16'd0) begin errors++; $display("FAIL pri_halt_flush_cnt: got %0d expected 0", if0.flush_cnt); end
    checks++; if (if0.stall_cnt !== 16'd1) begin errors++; $display("FAIL pri_halt_stall_cnt: got %0d expected 1", if0.stall_cnt); end
    tick();
  endtask

  task automatic test_halt();
    do_reset();
    halt_wb = 1;
    @(negedge clk);
    checks++; if (ctl0 !== 7'h70) begin errors++; $display("FAIL halt_entry: got %b expected %b", ctl0, 7'h70); end
    tick();
    idle();
    for (int i = 0; i < 10; i++) begin
      idle();
      if (i % 2 == 0) begin
        hazard(); br_taken_ex = 1; bta_ex = 5'h09;
      end
      @(negedge clk);
      checks++; if (ctl0 !== 7'h71) begin errors++; $display("FAIL halt_hold_%0d: got %b expected %b", i, ctl0, 7'h71); end
      checks++; if (if0.pc_target !== 5'h00) begin errors++; $display("FAIL halt_target_%0d: got %h expected 00", i, if0.pc_target); end
      tick();
    end
    checks++; if (if0.stall_cnt !== 16'd1) begin errors++; $display("FAIL halt_stall_cnt: got %0d expected 1", if0.stall_cnt); end
    checks++; if (if0.flush_cnt !== 16'd0) begin errors++; $display("FAIL halt_flush_cnt: got %0d expected 0", if0.flush_cnt); end
    rst = 1; hazard(); br_taken_ex = 1; bta_ex = 5'h11;
    @(negedge clk);
    checks++; if (ctl0 !== 7'h00) begin errors++; $display("FAIL halt_rst_ctl: got %b expected %b", ctl0, 7'h00); end
    tick();
    rst = 0;
    idle();
    @(negedge clk);
    checks++; if (ctl0 !== 7'h00) begin errors++; $display("FAIL halt_rst_exit: got %b expected %b", ctl0, 7'h00); end
    checks++; if (if0.stall_cnt !== 16'd0) begin errors++; $display("FAIL halt_rst_stall_cnt: got %0d expected 0", if0.stall_cnt); end
    checks++; if (if0.flush_cnt !== 16'd0) begin errors++; $display("FAIL halt_rst_flush_cnt: got %0d expected 0", if0.flush_cnt); end
    tick();
  endtask

  task automatic test_ld_stall3();
    int n;
    do_reset();
    n = 0;
    hazard();
    @(negedge clk);
    if (if3.stall_fe) n++;
    tick();
    idle();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (if3.stall_fe) n++;
      tick();
    end
    checks++; if (n !== 3) begin errors++; $display("FAIL ld3_cycles: got %0d expected 3", n); end
    checks++; if (if3.stall_cnt !== 16'd3) begin errors++; $display("FAIL ld3_stall_cnt: got %0d expected 3", if3.stall_cnt); end
    checks++; if (if0.stall_cnt !== 16'd1) begin errors++; $display("FAIL ld1_stall_cnt: got %0d expected 1", if0.stall_cnt); end
  endtask

  task automatic test_saturation();
    int e;
    do_reset();
    hazard();
    for (int i = 1; i <= 20; i++) begin
      tick();
      e = (i > 15) ? 15 : i;
      checks++; if (if4.stall_cnt !== 4'(e)) begin errors++; $display("FAIL sat_cnt_%0d: got %0d expected %0d", i, if4.stall_cnt, e); end
    end
    idle();
    checks++; if (if0.stall_cnt !== 16'd20) begin errors++; $display("FAIL sat_wide_cnt: got %0d expected 20", if0.stall_cnt); end
  endtask

  initial begin
    rst = 1;
    idle();
    tick();
    tick();
    test_reset();
    test_load_use();
    test_no_false_hazard();
    test_branch();
    test_priority();
    test_halt();
    test_ld_stall3();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
